// File: rtl/fetch_unit.sv
// Instruction fetch stage with one outstanding request, a 1-entry skid buffer and an IF/ID register.
// Latency: one cycle from imem_ack to IF/ID; stalls park the response in the buffer and drop imem_req.
module fetch_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        pc_wren,
  input  logic        IFID_wren,
  input  logic        IFID_clear,
  input  logic        EXMEM_pcsel,
  input  logic [31:0] i_redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFID_pc,
  output logic [31:0] IFID_instr,
  output logic        IFID_valid,
  output logic [15:0] drop_cnt
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [15:0] DROP_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_instr;
  logic        r_blank;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;
  logic [15:0] r_drop_cnt;

  logic        w_accept;
  logic        w_redirect;
  logic        w_ack;
  logic [31:0] w_target;
  logic [31:0] w_pc_inc;

  logic        w_imem_req;
  logic        w_load_mem;
  logic        w_load_buf;
  logic        w_buf_wr;
  logic        w_advance;
  logic        w_pc_tgt;
  logic        w_req_tgt;
  logic        w_req_pc;
  logic        w_drop;

  assign w_accept   = pc_wren & IFID_wren & ~IFID_clear;
  assign w_redirect = EXMEM_pcsel & IFID_clear;
  assign w_target   = {i_redirect_pc[31:2], 2'b00};
  assign w_pc_inc   = r_pc + 32'd4;

  // Acks in HOLD are protocol violations; the first cycle after reset may carry an abandoned response.
  assign w_ack = imem_ack & ~r_blank & (r_state != HOLD);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH: begin
        if (w_redirect) begin
          if (!w_ack) begin
            w_next_state = DROP;
          end
        end else if (w_ack && !w_accept) begin
          w_next_state = HOLD;
        end
      end
      HOLD: begin
        if (w_redirect || w_accept) begin
          w_next_state = FETCH;
        end
      end
      DROP: begin
        if (w_ack) begin
          w_next_state = FETCH;
        end
      end
      default: w_next_state = FETCH;
    endcase
  end

  always_comb begin
    w_imem_req = 1'b0;
    w_load_mem = 1'b0;
    w_load_buf = 1'b0;
    w_buf_wr   = 1'b0;
    w_advance  = 1'b0;
    w_pc_tgt   = 1'b0;
    w_req_tgt  = 1'b0;
    w_req_pc   = 1'b0;
    w_drop     = 1'b0;
    case (r_state)
      FETCH: begin
        w_imem_req = 1'b1;
        if (w_redirect) begin
          w_pc_tgt = 1'b1;
          if (w_ack) begin
            w_req_tgt = 1'b1;
            w_drop    = 1'b1;
          end
        end else if (w_ack) begin
          if (w_accept) begin
            w_load_mem = 1'b1;
            w_advance  = 1'b1;
          end else begin
            w_buf_wr = 1'b1;
          end
        end
      end
      HOLD: begin
        if (w_redirect) begin
          w_pc_tgt  = 1'b1;
          w_req_tgt = 1'b1;
        end else if (w_accept) begin
          w_load_buf = 1'b1;
          w_advance  = 1'b1;
        end
      end
      DROP: begin
        w_imem_req = 1'b1;
        if (w_redirect) begin
          w_pc_tgt = 1'b1;
        end
        // The stale response retires the old request; refetch from wherever pc now points.
        if (w_ack) begin
          w_drop = 1'b1;
          if (w_redirect) begin
            w_req_tgt = 1'b1;
          end else begin
            w_req_pc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc         <= 32'd0;
      r_req_addr   <= 32'd0;
      r_buf_pc     <= 32'd0;
      r_buf_instr  <= 32'd0;
      r_blank      <= 1'b1;
      r_ifid_pc    <= 32'd0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
      r_drop_cnt   <= 16'd0;
    end else begin
      r_blank <= 1'b0;

      if (w_pc_tgt) begin
        r_pc <= w_target;
      end else if (w_advance) begin
        r_pc <= w_pc_inc;
      end

      if (w_req_tgt) begin
        r_req_addr <= w_target;
      end else if (w_advance) begin
        r_req_addr <= w_pc_inc;
      end else if (w_req_pc) begin
        r_req_addr <= r_pc;
      end

      if (w_buf_wr) begin
        r_buf_pc    <= r_req_addr;
        r_buf_instr <= imem_rdata;
      end

      if (IFID_clear) begin
        r_ifid_pc    <= 32'd0;
        r_ifid_instr <= NOP_INSTR;
        r_ifid_valid <= 1'b0;
      end else if (w_load_mem) begin
        r_ifid_pc    <= r_req_addr;
        r_ifid_instr <= imem_rdata;
        r_ifid_valid <= 1'b1;
      end else if (w_load_buf) begin
        r_ifid_pc    <= r_buf_pc;
        r_ifid_instr <= r_buf_instr;
        r_ifid_valid <= 1'b1;
      end

      if (w_drop && (r_drop_cnt != DROP_MAX)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign imem_req   = w_imem_req & ~i_rst;
  assign imem_addr  = r_req_addr;
  assign IFID_pc    = r_ifid_pc;
  assign IFID_instr = r_ifid_instr;
  assign IFID_valid = r_ifid_valid;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios then randomized traffic, checked against a request/buffer level reference model.
module tb_fetch_unit;

  logic        i_clk;
  logic        i_rst;
  logic        pc_wren;
  logic        IFID_wren;
  logic        IFID_clear;
  logic        EXMEM_pcsel;
  logic [31:0] i_redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IFID_pc;
  logic [31:0] IFID_instr;
  logic        IFID_valid;
  logic [15:0] drop_cnt;

  int checks;
  int errors;

  fetch_unit dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .pc_wren      (pc_wren),
    .IFID_wren    (IFID_wren),
    .IFID_clear   (IFID_clear),
    .EXMEM_pcsel  (EXMEM_pcsel),
    .i_redirect_pc(i_redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .IFID_pc      (IFID_pc),
    .IFID_instr   (IFID_instr),
    .IFID_valid   (IFID_valid),
    .drop_cnt     (drop_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: next PC, address of the request in flight, whether that request is stale,
  // a parked response (stall), the IF/ID contents and the drop counter.
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic        m_stale;
  logic        m_parked;
  logic [31:0] m_park_pc;
  logic [31:0] m_park_instr;
  logic [31:0] m_ifid_pc;
  logic [31:0] m_ifid_instr;
  logic        m_ifid_valid;
  int          m_drops;
  logic        m_fresh;

  task automatic count_drop();
    if (m_drops < 65535) m_drops++;
  endtask

  task automatic model_edge();
    logic        ack_seen;
    logic        acc;
    logic        redir;
    logic [31:0] tgt;
    logic        ld;
    logic [31:0] ld_pc;
    logic [31:0] ld_instr;
    if (i_rst) begin
      m_pc = 0; m_addr = 0; m_stale = 0; m_parked = 0;
      m_park_pc = 0; m_park_instr = 0;
      m_ifid_pc = 0; m_ifid_instr = 32'h13; m_ifid_valid = 0;
      m_drops = 0; m_fresh = 1;
    end else begin
      ack_seen = imem_ack && !m_fresh && !m_parked;
      m_fresh  = 0;
      acc      = pc_wren && IFID_wren && !IFID_clear;
      redir    = EXMEM_pcsel && IFID_clear;
      tgt      = i_redirect_pc & 32'hFFFF_FFFC;
      ld = 0; ld_pc = 0; ld_instr = 0;
      if (m_parked) begin
        if (redir) begin
          m_parked = 0; m_pc = tgt; m_addr = tgt;
        end else if (acc) begin
          ld = 1; ld_pc = m_park_pc; ld_instr = m_park_instr;
          m_parked = 0; m_pc = m_pc + 4; m_addr = m_pc;
        end
      end else if (m_stale) begin
        if (redir) m_pc = tgt;
        if (ack_seen) begin
          count_drop(); m_stale = 0; m_addr = m_pc;
        end
      end else if (redir) begin
        m_pc = tgt;
        if (ack_seen) begin
          count_drop(); m_addr = tgt;
        end else begin
          m_stale = 1;
        end
      end else if (ack_seen) begin
        if (acc) begin
          ld = 1; ld_pc = m_addr; ld_instr = imem_rdata;
          m_pc = m_pc + 4; m_addr = m_pc;
        end else begin
          m_parked = 1; m_park_pc = m_addr; m_park_instr = imem_rdata;
        end
      end
      if (IFID_clear) begin
        m_ifid_pc = 0; m_ifid_instr = 32'h13; m_ifid_valid = 0;
      end else if (ld) begin
        m_ifid_pc = ld_pc; m_ifid_instr = ld_instr; m_ifid_valid = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_req", {31'd0, imem_req}, {31'd0, !i_rst && !m_parked});
    chk("imem_addr", imem_addr, m_addr);
    chk("IFID_pc", IFID_pc, m_ifid_pc);
    chk("IFID_instr", IFID_instr, m_ifid_instr);
    chk("IFID_valid", {31'd0, IFID_valid}, {31'd0, m_ifid_valid});
    chk("drop_cnt", {16'd0, drop_cnt}, m_drops[31:0]);
  endtask

  // Called just after an active edge with inputs already applied; returns just after the next edge.
  task automatic cyc();
    #1;
    chk("imem_req_pre", {31'd0, imem_req}, {31'd0, !i_rst && !m_parked});
    @(posedge i_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_in(input logic pw, input logic iw, input logic clr, input logic sel,
                        input logic [31:0] tgt, input logic ack, input logic [31:0] rd,
                        input logic rst);
    pc_wren = pw; IFID_wren = iw; IFID_clear = clr; EXMEM_pcsel = sel;
    i_redirect_pc = tgt; imem_ack = ack; imem_rdata = rd; i_rst = rst;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_fresh = 1; m_parked = 0; m_stale = 0; m_drops = 0;

    // Reset state
    set_in(1, 1, 0, 0, 0, 0, 0, 1);
    cyc();
    chk("rst_IFID_instr", IFID_instr, 32'h0000_0013);
    chk("rst_IFID_valid", {31'd0, IFID_valid}, 32'd0);
    chk("rst_IFID_pc", IFID_pc, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);

    // Streaming: ack every cycle with rdata = address; first post-reset ack is discarded
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 0, 0, 0, 1, m_addr, 0);
      cyc();
      if (i == 0) chk("blank_valid", {31'd0, IFID_valid}, 32'd0);
      else begin
        chk("stream_pc", IFID_pc, (i - 1) * 4);
        chk("stream_instr", IFID_instr, (i - 1) * 4);
        chk("stream_valid", {31'd0, IFID_valid}, 32'd1);
      end
    end
    chk("stream_addr", imem_addr, 32'h8);

    // Stall on the ack for 0x8
    set_in(0, 0, 0, 0, 0, 1, 32'h8, 0);
    cyc();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      chk("hold_IFID_pc", IFID_pc, 32'h4);
    end
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("release_IFID_pc", IFID_pc, 32'h8);
    chk("release_IFID_instr", IFID_instr, 32'h8);
    chk("release_addr", imem_addr, 32'hC);

    // Redirect to 0x100 while 0x10 is outstanding
    set_in(1, 1, 0, 0, 0, 1, 32'hC, 0);
    cyc();
    chk("pre_drop_addr", imem_addr, 32'h10);
    set_in(1, 0, 1, 1, 32'h100, 0, 0, 0);
    cyc();
    chk("drop_addr_kept", imem_addr, 32'h10);
    chk("drop_req", {31'd0, imem_req}, 32'd1);
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    cyc();
    set_in(1, 1, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    cyc();
    chk("drop_cnt_1", {16'd0, drop_cnt}, 32'd1);
    chk("drop_refetch_addr", imem_addr, 32'h100);
    chk("drop_valid", {31'd0, IFID_valid}, 32'd0);

    // Redirect to an unaligned target with a same-cycle ack
    set_in(1, 1, 1, 1, 32'h203, 1, 32'hBEEF, 0);
    cyc();
    chk("redir_ack_valid", {31'd0, IFID_valid}, 32'd0);
    chk("redir_ack_instr", IFID_instr, 32'h0000_0013);
    chk("redir_ack_addr", imem_addr, 32'h200);

    // PC wrap and drop counter saturation
    set_in(1, 1, 1, 1, 32'hFFFF_FFFC, 1, 32'h1, 0);
    cyc();
    set_in(1, 1, 0, 0, 0, 1, 32'h5555_AAAA, 0);
    cyc();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_IFID_pc", IFID_pc, 32'hFFFF_FFFC);
    for (int i = 0; i < 65540; i++) begin
      set_in(1, 1, 1, 1, $urandom, 1, $urandom, 0);
      cyc();
    end
    chk("drop_sat", {16'd0, drop_cnt}, 32'hFFFF);

    // Reset while waiting on 0x40
    set_in(1, 1, 1, 1, 32'h40, 1, 0, 0);
    cyc();
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("wait_addr", imem_addr, 32'h40);
    set_in(1, 1, 0, 0, 0, 0, 0, 1);
    #1;
    chk("rst_req_comb", {31'd0, imem_req}, 32'd0);
    cyc();
    chk("rst2_addr", imem_addr, 32'h0);
    chk("rst2_drop", {16'd0, drop_cnt}, 32'd0);
    set_in(1, 1, 0, 0, 0, 1, 32'h40, 0);
    cyc();
    chk("rst2_blank_valid", {31'd0, IFID_valid}, 32'd0);
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("rst2_wait_valid", {31'd0, IFID_valid}, 32'd0);
    set_in(1, 1, 0, 0, 0, 1, 32'h1234, 0);
    cyc();
    chk("rst2_first_valid", {31'd0, IFID_valid}, 32'd1);
    chk("rst2_first_pc", IFID_pc, 32'h0);
    chk("rst2_first_instr", IFID_instr, 32'h1234);

    // Randomized traffic, including acks during a stall and occasional resets
    for (int i = 0; i < 4000; i++) begin
      logic clr;
      logic ack;
      clr = ($urandom_range(0, 7) == 0);
      if (!m_parked) ack = ($urandom_range(0, 1) == 1);
      else           ack = ($urandom_range(0, 15) == 0);
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, clr,
             $urandom_range(0, 1) == 1, $urandom, ack, $urandom,
             $urandom_range(0, 199) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
